lcd_frame_sink: RTL and testbench
=================================

# lcd_frame_sink

Downstream capture stage for the LCD controller pixel stream. Collects each 16-pixel display window (4×4, raster order) emitted on `dataout`/`output_valid` into a double-buffered frame store. Computes per-frame statistics: sum, min and max. Presents completed frames to the display/scoreboard side through a registered random-access read port with a ready/ack handshake.

## Interface
- `DW`, 8: pixel width.
- `NPIX`, 16: pixels per frame; fixed 4×4 window.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pix_in` in DW: pixel from controller `dataout`.
- `pix_valid` in 1: controller `output_valid`; one pixel accepted per cycle while high.
- `src_busy` in 1: controller `busy`; its falling edge marks end of a command's output burst.
- `rd_addr` in 4: read index, raster order (row*4+col).
- `rd_data` out DW: pixel at `rd_addr` in read bank, 1-cycle latency.
- `frame_ready` out 1: read bank holds a complete, unacknowledged frame.
- `frame_ack` in 1: one-cycle pulse; releases read bank.
- `frame_sum` out 12: sum of 16 pixels of read bank (max 4080, no overflow).
- `frame_min` out DW: minimum pixel of read bank.
- `frame_max` out DW: maximum pixel of read bank.
- `drop_cnt` out 8: frames dropped because read bank was held; saturates at 255.
- `err_short` out 1: sticky; burst ended with 1..15 pixels.
- `err_long` out 1: sticky; pixel arrived after 16th in same burst.

## Operation
- Two banks of 16×DW; `wsel` selects write bank, the other is read bank. Reset: `wsel`=0, write count 0, all outputs 0, `frame_ready`=0, `frame_min`=0, `frame_max`=0, errors clear.
- Write FSM states: IDLE, FILL, FULL.
- IDLE: first valid pixel writes index 0, count=1, running min=max=sum=pixel; go FILL.
- FILL: each valid pixel writes `bank[wsel][count]`, count+1, updates running sum/min/max. On the 16th pixel, go FULL with the completed frame.
- FULL: completion is resolved on the cycle after the 16th pixel is accepted.
  - If `frame_ready`=0, or `frame_ack` is asserted that cycle: toggle `wsel`, latch running stats into `frame_sum/min/max`, set `frame_ready`=1.
  - Otherwise discard the frame and increment `drop_cnt` (saturating); `wsel` is unchanged.
  - In both cases, wait in FULL for `src_busy` low, then go IDLE.
- Extra valid pixels in FULL: not written; set `err_long`.
- `src_busy` falling edge (registered prior value 1, current 0) while in FILL: set `err_short`, discard the partial frame, return to IDLE, count=0.
- A `src_busy` edge in IDLE with no pixels is legal; no error.
- `frame_ack` with `frame_ready`=1 clears `frame_ready` next cycle unless a completion publishes in the same cycle, in which case `frame_ready` stays 1 with new contents. `frame_ack` while `frame_ready`=0 is ignored.
- Stat outputs and read bank contents are stable while `frame_ready`=1.
- Error flags and `drop_cnt` clear only on reset.

## Timing
- Pixel accepted on a clk edge where `pix_valid`=1; no backpressure. The sink must absorb one pixel per cycle indefinitely.
- `rd_data` is registered: valid one cycle after `rd_addr` is presented. It reflects the current read bank; reading while `frame_ready`=0 returns stale data.
- Latency from 16th pixel edge to `frame_ready`=1 is 2 edges: FULL entry, then publish.
- Minimum gap between consecutive frames: 1 idle cycle (controller busy low then WAIT→PROCESS). The FSM must be back in IDLE within that gap.
- Reset asserted mid-frame: immediate clear, partial data discarded, no error flag set.

## Test plan
- Single frame: pixels 1..16 with `pix_valid` continuous, then busy falls. Required: `frame_ready`=1 two cycles after last pixel; `frame_sum`=136; min=1; max=16; `rd_addr`=5 gives `rd_data`=6 one cycle later.
- Back-to-back frames without ack: frame A all 0x10, then frame B all 0x20. Required: read bank stays A (sum=256); `drop_cnt`=1.
- Back-to-back frames with `frame_ack` pulsed on B's publish cycle: Required: `frame_ready` held at 1; stats switch to B (sum=512, min=max=0x20); `drop_cnt`=0.
- Short burst: 5 pixels, then busy falls. Required: `err_short`=1, `frame_ready` unchanged. A following full frame of 0xFF gives sum=4080, max=0xFF.
- Long burst: 17 pixels in one burst. Required: `err_long`=1; frame published from the first 16 pixels; 17th not stored.
- Reset at pixel 9, then a fresh 16-pixel frame of value 3. Required: all outputs 0 after reset; new frame sum=48; no error flags set.

Source files
------------

// File: rtl/lcd_frame_sink.sv
// Capture stage for the LCD pixel stream: double-buffered 4x4 frame store
// with per-frame sum/min/max and a ready/ack registered read port.
module lcd_frame_sink #(
  parameter int DW   = 8,
  parameter int NPIX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  input  logic          src_busy,
  input  logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_ready,
  input  logic          frame_ack,
  output logic [11:0]   frame_sum,
  output logic [DW-1:0] frame_min,
  output logic [DW-1:0] frame_max,
  output logic [7:0]    drop_cnt,
  output logic          err_short,
  output logic          err_long
);

  // IDLE: await first pixel | FILL: collecting pixels | FULL: publish/drop once, then wait busy low
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_bank [2][NPIX];
  logic          r_wsel;
  logic          r_pend;
  logic          r_busy_d;
  logic [3:0]    r_cnt;
  logic [11:0]   r_sum;
  logic [DW-1:0] r_min, r_max;

  logic          w_fall, w_wr, w_first, w_enter_full;
  logic          w_set_short, w_set_long, w_publish, w_drop;
  logic [3:0]    w_waddr;
  logic [11:0]   w_pix_ext;

  assign w_fall    = r_busy_d & ~src_busy;
  assign w_pix_ext = 12'(pix_in);
  assign w_waddr   = w_first ? 4'd0 : r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_wr         = 1'b0;
    w_first      = 1'b0;
    w_enter_full = 1'b0;
    w_set_short  = 1'b0;
    w_set_long   = 1'b0;
    w_publish    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pix_valid) begin
          w_wr       = 1'b1;
          w_first    = 1'b1;
          w_state_nx = S_FILL;
        end
      end
      S_FILL: begin
        if (w_fall) begin
          w_set_short = 1'b1;
          w_state_nx  = S_IDLE;
        end else if (pix_valid) begin
          w_wr = 1'b1;
          if (r_cnt == 4'(NPIX - 1)) begin
            w_enter_full = 1'b1;
            w_state_nx   = S_FULL;
          end
        end
      end
      S_FULL: begin
        w_set_long = pix_valid;
        // Completion is resolved exactly once, on the first FULL cycle.
        if (r_pend) begin
          w_publish = ~frame_ready | frame_ack;
          w_drop    = frame_ready & ~frame_ack;
        end
        if (!src_busy) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wsel      <= 1'b0;
      r_pend      <= 1'b0;
      r_busy_d    <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      frame_ready <= 1'b0;
      frame_sum   <= '0;
      frame_min   <= '0;
      frame_max   <= '0;
      drop_cnt    <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      r_pend   <= w_enter_full;
      r_busy_d <= src_busy;

      if (w_first)          r_cnt <= 4'd1;
      else if (w_wr)        r_cnt <= r_cnt + 4'd1;
      else if (w_set_short) r_cnt <= '0;

      if (w_first) begin
        r_sum <= w_pix_ext;
        r_min <= pix_in;
        r_max <= pix_in;
      end else if (w_wr) begin
        r_sum <= r_sum + w_pix_ext;
        if (pix_in < r_min) r_min <= pix_in;
        if (pix_in > r_max) r_max <= pix_in;
      end

      if (w_publish) begin
        r_wsel      <= ~r_wsel;
        frame_sum   <= r_sum;
        frame_min   <= r_min;
        frame_max   <= r_max;
        frame_ready <= 1'b1;
      end else if (frame_ack) begin
        frame_ready <= 1'b0;
      end

      if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (w_set_short) err_short <= 1'b1;
      if (w_set_long)  err_long  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_bank[r_wsel][w_waddr] <= pix_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= r_bank[~r_wsel][rd_addr];
  end

endmodule

// File: tb/tb_lcd_frame_sink.sv
// Randomized scoreboard bench for lcd_frame_sink: a frame-level reference model
// queues expected stats; a monitor pops them whenever a new frame is presented.
module tb_lcd_frame_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        src_busy;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_ready;
  logic        frame_ack;
  logic [11:0] frame_sum;
  logic [7:0]  frame_min;
  logic [7:0]  frame_max;
  logic [7:0]  drop_cnt;
  logic        err_short;
  logic        err_long;

  lcd_frame_sink #(.DW(8), .NPIX(16)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .src_busy(src_busy), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .frame_sum(frame_sum),
    .frame_min(frame_min), .frame_max(frame_max), .drop_cnt(drop_cnt),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  typedef struct {int sum; int mn; int mx;} stats_t;

  int         n_checks = 0;
  int         n_err = 0;
  stats_t     q[$];
  logic [7:0] px[20];
  logic [7:0] m_rb[16];
  bit         m_has, m_ready, m_es, m_el;
  int         m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stats_t stats_of(input logic [7:0] a[16]);
    stats_t s;
    s.sum = 0; s.mn = 255; s.mx = 0;
    foreach (a[i]) begin
      s.sum += int'(a[i]);
      if (int'(a[i]) < s.mn) s.mn = int'(a[i]);
      if (int'(a[i]) > s.mx) s.mx = int'(a[i]);
    end
    return s;
  endfunction

  // Monitor: a new frame is presented when ready rises, or stays up across an ack.
  bit last_ready = 1'b0, last_ack = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      last_ready = 1'b0;
      last_ack   = 1'b0;
    end else begin
      if (frame_ready && (!last_ready || last_ack)) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame: got sum %0d expected no frame", frame_sum);
        end else begin
          stats_t e;
          e = q.pop_front();
          chk("mon_sum", 32'(frame_sum), e.sum);
          chk("mon_min", 32'(frame_min), e.mn);
          chk("mon_max", 32'(frame_max), e.mx);
        end
      end
      last_ready = frame_ready;
      last_ack   = frame_ack;
    end
  end

  task automatic do_reset();
    reset = 1'b1; pix_valid = 1'b0; src_busy = 1'b0; frame_ack = 1'b0;
    rd_addr = '0; pix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("pending_frames", q.size(), 0);
    q.delete();
    chk("rst_ready", 32'(frame_ready), 0);
    chk("rst_sum",   32'(frame_sum), 0);
    chk("rst_min",   32'(frame_min), 0);
    chk("rst_max",   32'(frame_max), 0);
    chk("rst_drop",  32'(drop_cnt), 0);
    chk("rst_eshort", 32'(err_short), 0);
    chk("rst_elong", 32'(err_long), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    m_has = 0; m_ready = 0; m_es = 0; m_el = 0; m_drop = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fill(input int n, input int val);
    for (int i = 0; i < n; i++) px[i] = (val < 0) ? 8'($urandom) : 8'(val);
  endtask

  // Drives px[0..n-1] as one busy burst; ack (16-pixel bursts only) lands on the publish cycle.
  task automatic send_burst(input int n, input bit ack);
    bit pub = 0;
    bit was_ready = m_ready;
    bit ack_eff = ack && (n == 16);
    if (n >= 16) begin
      logic [7:0] f[16];
      for (int i = 0; i < 16; i++) f[i] = px[i];
      if (!m_ready || ack_eff) begin
        pub = 1; m_ready = 1; m_has = 1;
        m_rb = f;
        q.push_back(stats_of(f));
      end else if (m_drop < 255) begin
        m_drop++;
      end
      if (n > 16) m_el = 1;
    end else if (n > 0) begin
      m_es = 1;
    end
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; pix_in = px[i]; src_busy = 1'b1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; pix_in = 8'($urandom); src_busy = 1'b0; frame_ack = ack_eff;
    if (pub && !was_ready && n == 16) chk("ready_latency_early", 32'(frame_ready), 0);
    @(posedge clk); #1;
    frame_ack = 1'b0;
    if (pub && n == 16) chk("ready_latency", 32'(frame_ready), 1);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    m_ready = 0;
    chk("ack_clears_ready", 32'(frame_ready), 0);
  endtask

  task automatic check_state();
    chk("ready",     32'(frame_ready), 32'(m_ready));
    chk("drop_cnt",  32'(drop_cnt), m_drop);
    chk("err_short", 32'(err_short), 32'(m_es));
    chk("err_long",  32'(err_long), 32'(m_el));
    if (m_has) begin
      stats_t s;
      s = stats_of(m_rb);
      chk("sum", 32'(frame_sum), s.sum);
      chk("min", 32'(frame_min), s.mn);
      chk("max", 32'(frame_max), s.mx);
    end
  endtask

  task automatic readback(input int n);
    for (int k = 0; k < n; k++) begin
      int a;
      a = (k == 0) ? 5 : int'($urandom_range(0, 15));
      rd_addr = 4'(a);
      @(posedge clk); #1;
      chk("rd_data", 32'(rd_data), 32'(m_rb[a]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    do_reset();

    // Single frame 1..16
    for (int i = 0; i < 16; i++) px[i] = 8'(i + 1);
    send_burst(16, 0);
    check_state();
    readback(8);

    // Back-to-back without ack: second frame dropped
    do_reset();
    fill(16, 8'h10); send_burst(16, 0);
    fill(16, 8'h20); send_burst(16, 0);
    check_state();
    readback(4);

    // Back-to-back with ack on the publish cycle
    do_reset();
    fill(16, 8'h10); send_burst(16, 0);
    fill(16, 8'h20); send_burst(16, 1);
    check_state();
    readback(4);

    // Short burst, then full-scale frame
    do_reset();
    fill(5, -1); send_burst(5, 0);
    check_state();
    fill(16, 8'hFF); send_burst(16, 0);
    check_state();

    // Long burst
    do_reset();
    fill(17, -1); send_burst(17, 0);
    check_state();
    readback(16);

    // Reset mid-frame, then a fresh frame
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pix_valid = 1'b1; pix_in = 8'($urandom); src_busy = 1'b1;
      @(posedge clk); #1;
    end
    do_reset();
    fill(16, 3); send_burst(16, 0);
    check_state();

    // Randomized traffic
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int r, n;
      r = int'($urandom_range(0, 9));
      if (r < 6)      n = 16;
      else if (r < 8) n = int'($urandom_range(1, 15));
      else            n = int'($urandom_range(17, 19));
      fill(n, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1);
      send_burst(n, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) ack_frame();
      check_state();
      if (m_has && $urandom_range(0, 3) == 0) readback(3);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_pending_frames", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
